// File: rtl/mips_mc_control_pkg.sv
// Shared declarations for the multicycle MIPS controller: opcodes, FSM state
// encoding, ALU class codes and datapath mux select codes.
// Ports: none (package mips_decls_p).
package mips_decls_p;

  // Primary opcodes, taken from instr[31:26].
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ORI   = 6'h0d,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEX    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IMMWB   = 4'd12,
    S_JMP     = 4'd13,
    S_ILLEGAL = 4'd14
  } mc_state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;  // PC+4 straight from the ALU
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // branch target held in ALUOut
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;  // immediate << 2

  // States that wait on mem_ready and are covered by the timeout counter.
  function automatic logic is_wait_state(mc_state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_control_mc_wait_timer.sv
// Memory wait counter: clears on entry to a wait state, counts cycles spent
// waiting with mem_ready low, saturates at MEM_TIMEOUT and flags the timeout.
// Ports: clk, rst (sync, active-high), clear_i, wait_i, mem_ready_i, timeout_o.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,      // next cycle is the first in a wait state
  input  logic wait_i,       // current state is a wait state
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam logic [TW-1:0] CNT_MAX = TW'(MEM_TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          stalled;

  assign stalled = wait_i && !mem_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (stalled && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A ready in the limit cycle completes the access, so ready suppresses it.
  assign timeout_o = stalled && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: steps the shared-memory datapath through
// fetch/decode/execute/memory/writeback with a memory-wait timeout.
// Ports: clk, rst (sync, active-high), opcode, mem_ready -> datapath enables,
// mux selects, mem_err pulse, state_o debug; illegal_op only when
// MIPS_MC_ILLEGAL_TRAP_EN is defined (ILLEGAL becomes a terminal trap state).
module mips_mc_control
  import mips_decls_p::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  opcode_t    opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic       branch,
  output logic       branchne,
  output logic       sign_extend_enb,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       mem_err,
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state_o
);

  mc_state_t state_q, state_d;
  logic      timeout;
  logic      timer_clear;

  // Counter restarts whenever we arrive in a wait state, including the
  // FETCH->FETCH retry after a fetch timeout.
  assign timer_clear = is_wait_state(state_d) && ((state_d != state_q) || timeout);

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TW          (TW)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (timer_clear),
    .wait_i      (is_wait_state(state_q)),
    .mem_ready_i (mem_ready),
    .timeout_o   (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    pcwrite         = 1'b0;
    irwrite         = 1'b0;
    regwrite        = 1'b0;
    memwrite        = 1'b0;
    iord            = 1'b0;
    memtoreg        = 1'b0;
    regdst          = 1'b0;
    alusrca         = 1'b0;
    branch          = 1'b0;
    branchne        = 1'b0;
    sign_extend_enb = 1'b0;
    alusrcb         = ALUSRCB_REG;
    pcsrc           = PCSRC_ALU;
    aluop           = ALUOP_ADD;

    unique case (state_q)
      S_FETCH: begin
        alusrcb = ALUSRCB_FOUR;
        if (mem_ready) begin
          pcwrite = 1'b1;
          irwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb         = ALUSRCB_IMMSH;
        sign_extend_enb = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca         = 1'b1;
        alusrcb         = ALUSRCB_IMM;
        sign_extend_enb = 1'b1;
        if (opcode == OP_SW)      state_d = S_MEMWR;
        else if (opcode == OP_LW) state_d = S_MEMRD;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branch   = (state_q == S_BEQEX);
        branchne = (state_q == S_BNEEX);
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca         = 1'b1;
        alusrcb         = ALUSRCB_IMM;
        sign_extend_enb = 1'b1;
        state_d         = S_IMMWB;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        aluop   = ALUOP_OR;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // An instruction interrupted by reset must not commit anything.
    if (rst) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign mem_err = timeout && !rst;
  assign state_o = state_q;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;
  import mips_decls_p::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  opcode_t    opcode;
  logic       mem_ready;
  logic       pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst;
  logic       alusrca, branch, branchne, sign_extend_enb, mem_err;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state_o;
  logic       ill_act;

  mips_mc_control #(.MEM_TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .branch(branch), .branchne(branchne), .sign_extend_enb(sign_extend_enb),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .mem_err(mem_err),
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    .illegal_op(ill_act),
`endif
    .state_o(state_o)
  );

`ifndef MIPS_MC_ILLEGAL_TRAP_EN
  assign ill_act = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One planned cycle: the state the DUT should be in, the mem_ready driven
  // during it, and whether a timeout pulse is due in it.
  typedef struct {
    mc_state_t st;
    logic      rdy;
    logic      err;
  } step_t;

  step_t plan[$];
  int    forced[$];

  wire [18:0] act_vec = {pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
                         alusrca, branch, branchne, sign_extend_enb,
                         alusrcb, pcsrc, aluop, mem_err, ill_act};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a state, written from the per-state output list.
  function automatic logic [18:0] exp_ctrl(mc_state_t st, logic rdy, logic err);
    logic pw = 0, iw = 0, rw = 0, mw = 0, io = 0, mr = 0, rd = 0, sa = 0;
    logic br = 0, bn = 0, se = 0, ill = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00, ao = 2'b00;
    case (st)
      S_FETCH:   begin sb = 2'b01; pw = rdy; iw = rdy; end
      S_DECODE:  begin sb = 2'b11; se = 1; end
      S_MEMADR:  begin sa = 1; sb = 2'b10; se = 1; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin rw = 1; mr = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_RTEX:    begin sa = 1; ao = 2'b10; end
      S_ALUWB:   begin rw = 1; rd = 1; end
      S_BEQEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      S_BNEEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; se = 1; end
      S_ORIEX:   begin sa = 1; sb = 2'b10; ao = 2'b11; end
      S_IMMWB:   rw = 1;
      S_JMP:     begin ps = 2'b10; pw = 1; end
      default:   ;
    endcase
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    ill = (st == S_ILLEGAL);
`endif
    return {pw, iw, rw, mw, io, mr, rd, sa, br, bn, se, sb, ps, ao, err, ill};
  endfunction

  // Number of mem_ready-low cycles before ready; anything above TO times out.
  function automatic int next_delay();
    if (forced.size() > 0) return forced.pop_front();
    return int'($urandom_range(0, TO + 2));
  endfunction

  task automatic add_wait(input mc_state_t s, output bit done);
    int d;
    int lows;
    d    = next_delay();
    lows = (d > TO) ? TO + 1 : d;
    for (int i = 0; i < lows; i++) plan.push_back('{s, 1'b0, (i == TO)});
    done = (d <= TO);
    if (done) plan.push_back('{s, 1'b1, 1'b0});
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push1(input mc_state_t s);
    plan.push_back('{s, rnd_bit(), 1'b0});
  endtask

  // Expected cycle-by-cycle walk of one instruction.
  task automatic build(input opcode_t op);
    bit ok;
    opcode = op;
    do add_wait(S_FETCH, ok); while (!ok);
    push1(S_DECODE);
    case (op)
      OP_LW:    begin push1(S_MEMADR); add_wait(S_MEMRD, ok); if (ok) push1(S_MEMWB); end
      OP_SW:    begin push1(S_MEMADR); add_wait(S_MEMWR, ok); end
      OP_RTYPE: begin push1(S_RTEX);   push1(S_ALUWB); end
      OP_BEQ:   push1(S_BEQEX);
      OP_BNE:   push1(S_BNEEX);
      OP_ADDI:  begin push1(S_ADDIEX); push1(S_IMMWB); end
      OP_ORI:   begin push1(S_ORIEX);  push1(S_IMMWB); end
      OP_J:     push1(S_JMP);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      default:  for (int i = 0; i < 5; i++) push1(S_ILLEGAL);
`else
      default:  push1(S_ILLEGAL);
`endif
    endcase
  endtask

  task automatic run_plan(input string tag);
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = s.rdy;
      #1;
      check({tag, "_state"}, 32'(state_o), 32'(s.st));
      check({tag, "_ctrl"},  32'(act_vec), 32'(exp_ctrl(s.st, s.rdy, s.err)));
    end
  endtask

  // Leaves rst high at a negedge; the next run_plan step releases it.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_state"}, 32'(state_o), 32'(S_FETCH));
    check({tag, "_ctrl"},  32'(act_vec), 32'(exp_ctrl(S_FETCH, 1'b0, 1'b0)));
  endtask

  opcode_t pool[$];

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = OP_RTYPE;
    do_reset("reset");

    forced = '{0, 0};      build(OP_LW);  run_plan("lw_ready");
    forced = '{0, 3};      build(OP_SW);  run_plan("sw_wait3");
    forced = '{0};         build(OP_BEQ); run_plan("beq");
    forced = '{0};         build(OP_BNE); run_plan("bne");
    forced = '{0};         build(OP_J);   run_plan("j");
    forced = '{0, TO + 1}; build(OP_LW);  run_plan("lw_timeout");
    forced = '{0, TO};     build(OP_LW);  run_plan("lw_ready_at_limit");
    forced = '{TO + 1, 0}; build(OP_ORI); run_plan("fetch_timeout");
    forced = '{0};         build(opcode_t'(6'h3f)); run_plan("illegal");
    do_reset("reset_after_illegal");

    pool = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
`ifndef MIPS_MC_ILLEGAL_TRAP_EN
    pool.push_back(opcode_t'(6'h3f));
    pool.push_back(opcode_t'(6'h11));
`endif
    for (int n = 0; n < 300; n++) begin
      build(pool[$urandom_range(0, pool.size() - 1)]);
      run_plan("random");
    end

    // Reset while a store is waiting: nothing may be written afterwards.
    forced = '{0, TO + 2};
    build(OP_SW);
    while (plan.size() > 5) void'(plan.pop_back());
    run_plan("sw_pre_reset");
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_memwr_state", 32'(state_o), 32'(S_FETCH));
    check("rst_in_memwr_ctrl",  32'(act_vec), 32'(exp_ctrl(S_FETCH, 1'b0, 1'b0)));
    do_reset("final_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
